// File: rtl/regfile_write_demux_if.sv
// Write-request channel into the register-file write distributor.
// Carries a valid/ready handshake with the target address and data word.
interface regfile_write_demux_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
);
    logic                  valid;
    logic                  ready;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;

    modport master (output valid, output addr, output data, input ready);
    modport slave  (input valid, input addr, input data, output ready);
endinterface

// File: rtl/regfile_write_demux.sv
// Write-side distributor: one-entry holding stage feeding a registered
// one-hot row enable and broadcast data word for the register file.
module regfile_write_demux #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int PROTECT_R0 = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    regfile_write_demux_if.slave       w,
    input  logic                       hold,
    output logic [2**ADDR_WIDTH-1:0]   we_out,
    output logic [DATA_WIDTH-1:0]      data_out,
    output logic                       busy,
    output logic [7:0]                 drop_cnt
);
    localparam int NT = 2**ADDR_WIDTH;

    typedef enum logic {EMPTY, FULL} state_t;

    state_t                state;
    state_t                state_nxt;
    logic [ADDR_WIDTH-1:0] ea;
    logic [DATA_WIDTH-1:0] ed;
    logic                  accept;
    logic                  issue;
    logic                  drop;
    logic [NT-1:0]         we_nxt;

    assign w.ready = (state == EMPTY) | ~hold;
    assign accept  = w.valid & w.ready;
    assign issue   = (state == FULL) & ~hold;
    assign drop    = issue & (PROTECT_R0 != 0) & (ea == '0);
    assign busy    = (state == FULL);

    always_comb begin
        state_nxt = state;
        we_nxt    = '0;
        unique case (state)
            EMPTY: if (accept) state_nxt = FULL;
            FULL:  if (issue && !accept) state_nxt = EMPTY;
            default: state_nxt = EMPTY;
        endcase
        if (issue && !drop) we_nxt[ea] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= EMPTY;
        else      state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ea       <= '0;
            ed       <= '0;
            we_out   <= '0;
            data_out <= '0;
            drop_cnt <= '0;
        end else begin
            if (accept) begin
                ea <= w.addr;
                ed <= w.data;
            end
            we_out <= we_nxt;
            if (issue) data_out <= ed;
            // saturate rather than wrap so the counter stays meaningful
            if (drop && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
        end
    end
endmodule

// File: tb/tb_regfile_write_demux.sv
// Randomized bench for regfile_write_demux against a queue-based model.
// Two instances run in lockstep: R0 protection on and off.
module tb_regfile_write_demux;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        v   = 1'b0;
    logic [4:0]  a   = '0;
    logic [31:0] d   = '0;
    logic        h   = 1'b0;

    logic [31:0] we0, we1, do0, do1;
    logic        busy0, busy1;
    logic [7:0]  dc0, dc1;

    regfile_write_demux_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) i0 ();
    regfile_write_demux_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) i1 ();

    assign i0.valid = v;
    assign i0.addr  = a;
    assign i0.data  = d;
    assign i1.valid = v;
    assign i1.addr  = a;
    assign i1.data  = d;

    regfile_write_demux #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .PROTECT_R0(1)) u0 (
        .clk(clk), .rst(rst), .w(i0.slave), .hold(h),
        .we_out(we0), .data_out(do0), .busy(busy0), .drop_cnt(dc0)
    );
    regfile_write_demux #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .PROTECT_R0(0)) u1 (
        .clk(clk), .rst(rst), .w(i1.slave), .hold(h),
        .we_out(we1), .data_out(do1), .busy(busy1), .drop_cnt(dc1)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct { logic [4:0] addr; logic [31:0] data; } req_t;
    req_t        q[$];
    logic [31:0] m_we0 = '0, m_we1 = '0, m_data = '0;
    int          m_drop = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic chk_out();
        chk("we_p1",   we0, m_we0);
        chk("we_p0",   we1, m_we1);
        chk("data_p1", do0, m_data);
        chk("data_p0", do1, m_data);
        chk("busy_p1", busy0, q.size() != 0);
        chk("busy_p0", busy1, q.size() != 0);
        chk("drop_p1", dc0, m_drop);
        chk("drop_p0", dc1, 0);
    endtask

    // One cycle: drive at negedge, check ready, model the edge, check outputs.
    task automatic cyc(input logic vv, input logic [4:0] aa, input logic [31:0] dd, input logic hh);
        bit   rdy, acc;
        req_t r;
        v = vv; a = aa; d = dd; h = hh;
        #1;
        rdy = (q.size() == 0) || !hh;
        acc = vv && rdy;
        chk("ready_p1", i0.ready, rdy);
        chk("ready_p0", i1.ready, rdy);
        @(posedge clk);
        m_we0 = '0;
        m_we1 = '0;
        if (q.size() != 0 && !hh) begin
            r = q.pop_front();
            m_data = r.data;
            m_we1  = 32'd1 << r.addr;
            if (r.addr == 0) begin
                if (m_drop < 255) m_drop++;
            end else begin
                m_we0 = 32'd1 << r.addr;
            end
        end
        if (acc) begin
            r.addr = aa;
            r.data = dd;
            q.push_back(r);
        end
        @(negedge clk);
        chk_out();
    endtask

    task automatic do_reset();
        v = 1'b0;
        rst = 1'b0;
        q.delete();
        m_we0 = '0; m_we1 = '0; m_data = '0; m_drop = 0;
        #1;
        chk_out();
        chk("rst_ready", i0.ready, 1'b1);
        @(posedge clk);
        @(negedge clk);
        chk_out();
        rst = 1'b1;
    endtask

    initial begin
        #12;
        @(negedge clk);
        do_reset();

        cyc(1'b1, 5'd5, 32'hDEADBEEF, 1'b0);
        cyc(1'b0, 5'd0, 32'h0, 1'b0);
        chk("single_we", we0, 32'h0000_0020);
        cyc(1'b0, 5'd0, 32'h0, 1'b0);
        chk("single_off", we0, 32'h0);

        for (int i = 1; i < 32; i++) cyc(1'b1, 5'(i), $urandom, 1'b0);
        cyc(1'b0, 5'd0, 32'h0, 1'b0);
        chk("stream_last", we0, 32'h8000_0000);

        cyc(1'b1, 5'd7, 32'h1234, 1'b0);
        for (int i = 0; i < 3; i++) cyc(1'b1, 5'd9, 32'h9999, 1'b1);
        cyc(1'b1, 5'd9, 32'h9999, 1'b0);
        chk("stall_first", we0, 32'h0000_0080);
        cyc(1'b0, 5'd0, 32'h0, 1'b0);
        chk("stall_second", we0, 32'h0000_0200);
        cyc(1'b0, 5'd0, 32'h0, 1'b0);

        for (int i = 0; i < 260; i++) cyc(1'b1, 5'd0, $urandom, 1'b0);
        cyc(1'b0, 5'd0, 32'h0, 1'b0);
        chk("drop_sat", dc0, 8'd255);

        for (int i = 0; i < 32; i++) cyc(1'b1, 5'(i), $urandom, 1'($urandom_range(0, 3) == 0));
        for (int i = 0; i < 4; i++) cyc(1'b0, 5'd0, 32'h0, 1'b0);

        for (int i = 0; i < 400; i++)
            cyc(1'($urandom_range(0, 3) != 0), 5'($urandom), $urandom,
                1'($urandom_range(0, 2) == 0));

        cyc(1'b1, 5'd3, 32'hAAAA_5555, 1'b0);
        cyc(1'b1, 5'd4, 32'h4444_4444, 1'b1);
        do_reset();
        for (int i = 0; i < 3; i++) cyc(1'b0, 5'd0, 32'h0, 1'b0);
        cyc(1'b1, 5'd0, 32'h0BAD_0000, 1'b0);
        cyc(1'b0, 5'd0, 32'h0, 1'b0);
        chk("r0_unprot", we1, 32'h0000_0001);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/regfile_write_demux.md
# regfile_write_demux

Write-side distributor for the 32x32 register file: accepts one write request (address, data) per cycle over a valid/ready handshake, buffers it in a single-entry holding stage, and issues it as a registered one-hot write-enable vector plus broadcast data word to the 32 register rows. It is the inverse of the read-side 32:1 word selection: a 5-bit address fans out to 32 targets instead of 32 sources collapsing to one. It sits between the writeback stage and the register file, absorbs writeback stalls through HOLD, and enforces the hard-wired-zero rule for R0.

## Interface
- DATA_WIDTH, 32, width of the write data word
- ADDR_WIDTH, 5, address width; number of targets is 2**ADDR_WIDTH (32)
- PROTECT_R0, 1, when 1, writes to address 0 are issued with no enable bit set and are counted as dropped
- CLK  in  1  clock; all state updates on the rising edge
- RST  in  1  reset, asynchronous, active-low
- W_VALID  in  1  write request valid
- W_READY  out  1  block can accept a request this cycle (combinational)
- W_ADDR  in  ADDR_WIDTH  target register index
- W_DATA  in  DATA_WIDTH  write data
- HOLD  in  1  downstream stall; while 1, no write is issued
- WE_OUT  out  2**ADDR_WIDTH  registered one-hot write enable, one bit per register row
- DATA_OUT  out  DATA_WIDTH  registered write data, broadcast to all rows
- BUSY  out  1  holding entry occupied (= FULL state)
- DROP_CNT  out  8  saturating count of suppressed R0 writes

## Operation
- Holding entry: state EMPTY/FULL (flag ev) plus stored address ea and data ed.
- W_READY = ~ev | ~HOLD. Accept = W_VALID & W_READY.
- Issue = ev & ~HOLD, evaluated on each rising CLK edge.
- On issue: WE_OUT <= onehot(ea), where bit ea = 1 and all other bits = 0. If PROTECT_R0 = 1 and ea = 0, WE_OUT <= 0 and DROP_CNT increments. DATA_OUT <= ed.
- No issue: WE_OUT <= 0. DATA_OUT holds its value.
- State transitions:
  - EMPTY -> FULL on accept.
  - FULL -> FULL on accept with simultaneous issue (pass-through; entry is replaced), or when HOLD = 1 (entry retained and inputs ignored).
  - FULL -> EMPTY on issue with no accept.
- ea/ed load only on accept.
- DROP_CNT saturates at 255 and never wraps.
- WE_OUT is never multi-hot. An address outside the range cannot occur because the width is exact.
- Reset (RST = 0, asynchronous): ev = 0, ea = 0, ed = 0, WE_OUT = 0, DATA_OUT = 0, DROP_CNT = 0. This gives BUSY = 0 and W_READY = 1. A pending entry is discarded with no WE pulse, and no WE pulse is produced while RST = 0.

## Timing
- Latency: a request accepted at edge k is issued at edge k+1 if HOLD = 0 in the cycle before k+1. WE_OUT is high for exactly the one cycle following that edge.
- Throughput is 1 write/cycle with HOLD = 0; back-to-back writes produce WE_OUT pulses on consecutive cycles.
- HOLD = 1 for N cycles delays issue by N cycles. At most one request is stored; W_READY is low only when FULL and HOLD = 1.
- Simultaneous accept and issue in the same cycle: the old entry issues and the new entry loads. No bubble, no loss.
- HOLD rising in the same cycle as a new accept while EMPTY: the request is accepted (W_READY = 1), and the block goes FULL and waits.
- RST deassertion: the first accept is possible at the first rising edge with RST = 1.
- Outputs change only on rising CLK or on RST assertion.

## Test plan
- Reset: drive RST = 0 mid-stream with an entry FULL and HOLD = 1 -> WE_OUT = 0, DATA_OUT = 0, DROP_CNT = 0, BUSY = 0, W_READY = 1 immediately. After release, no WE pulse occurs for the discarded entry.
- Single write: W_ADDR = 5, W_DATA = 0xDEADBEEF, HOLD = 0, accepted at edge k -> WE_OUT = 0x00000020 and DATA_OUT = 0xDEADBEEF for exactly the cycle after edge k+1, then WE_OUT = 0.
- Streaming: addresses 1..31 on consecutive cycles with HOLD = 0 -> 31 consecutive one-hot pulses 0x2 .. 0x80000000, each with matching data, and W_READY held at 1.
- Stall: accept addr 7, data 0x1234, then HOLD = 1 for 3 cycles while W_VALID = 1 with addr 9 -> W_READY = 0 and WE_OUT = 0 during the stall. After HOLD drops, the addr 7 pulse is issued first, then addr 9 on the next cycle; addr 9 data is neither lost nor duplicated.
- R0 protection: 260 writes to address 0 with PROTECT_R0 = 1 -> WE_OUT stays 0 and DROP_CNT = 255 (saturated). With PROTECT_R0 = 0, a write to address 0 -> WE_OUT = 0x00000001.
- Exhaustive decode: all 32 addresses with random data, checked against a reference one-hot model -> exactly one bit set per issue, and zero pulses on any non-issue cycle.
